// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: arbitrates left/right/hazard requests and steps a
// three-lamp brightness ramp per side at a prescaled tick rate.
module tail_light_sequencer #(
   parameter int unsigned TICK_DIV   = 4,
   parameter int unsigned HOLD_TICKS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        left,
   input  logic        right,
   input  logic        hazard,
   output logic [23:0] duty_l,
   output logic [23:0] duty_r,
   output logic        busy,
   output logic [1:0]  side
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int unsigned SW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned NL = 3;
   localparam int unsigned PW = DW * NL;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(11);

   typedef enum logic [1:0] {IDLE, RAMP, HOLD, GAP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [SW-1:0]   step_q, step_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [1:0]      side_q, side_d;
   logic [PW-1:0]   duty_l_q, duty_l_d;
   logic [PW-1:0]   duty_r_q, duty_r_d;
   logic            busy_q, busy_d;
   logic            strobe;
   logic [PW-1:0]   pattern;

   // Brightness level for position within a lamp's four-step ramp
   function automatic logic [DW-1:0] level_lut(input logic [1:0] idx);
      case (idx)
         2'd0:    level_lut = DW'(3);
         2'd1:    level_lut = DW'(15);
         2'd2:    level_lut = DW'(63);
         default: level_lut = DW'(255);
      endcase
   endfunction

   // Per-lamp duties for a ramp step: earlier lamps full, later lamps dark
   function automatic logic [PW-1:0] ramp_duty(input logic [SW-1:0] s);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NL); i++) begin
         if (2'(i) < s[3:2])
            r[i*DW +: DW] = DW'(255);
         else if (2'(i) == s[3:2])
            r[i*DW +: DW] = level_lut(s[1:0]);
      end
      return r;
   endfunction

   // Next-state, counters and registered-output values
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      step_d  = step_q;
      hold_d  = hold_q;
      side_d  = side_q;
      pattern = '0;
      strobe  = (tick_q == TICK_LAST);

      case (state_q)
         IDLE: begin
            tick_d = '0;
            step_d = '0;
            hold_d = '0;
            side_d = 2'b00;
            if (hazard) begin
               side_d  = 2'b11;
               state_d = RAMP;
            end else if (left && !right) begin
               side_d  = 2'b10;
               state_d = RAMP;
            end else if (right && !left) begin
               side_d  = 2'b01;
               state_d = RAMP;
            end
         end
         RAMP: begin
            tick_d = strobe ? '0 : tick_q + TW'(1);
            if (strobe) begin
               if (step_q == STEP_LAST) begin
                  state_d = HOLD;
                  step_d  = '0;
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
         end
         HOLD: begin
            tick_d = strobe ? '0 : tick_q + TW'(1);
            if (strobe) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = GAP;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         GAP: begin
            tick_d = strobe ? '0 : tick_q + TW'(1);
            if (strobe) begin
               state_d = IDLE;
               tick_d  = '0;
               side_d  = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            step_d  = '0;
            hold_d  = '0;
            side_d  = 2'b00;
         end
      endcase

      // An out-of-range step count can only come from corruption: recover to IDLE
      if ((state_q != IDLE) && (step_q > STEP_LAST)) begin
         state_d = IDLE;
         tick_d  = '0;
         step_d  = '0;
         hold_d  = '0;
         side_d  = 2'b00;
      end

      case (state_d)
         RAMP:    pattern = ramp_duty(step_d);
         HOLD:    pattern = '1;
         default: pattern = '0;
      endcase

      duty_l_d = side_d[1] ? pattern : '0;
      duty_r_d = side_d[0] ? pattern : '0;
      busy_d   = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         step_q   <= '0;
         hold_q   <= '0;
         side_q   <= 2'b00;
         duty_l_q <= '0;
         duty_r_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         step_q   <= step_d;
         hold_q   <= hold_d;
         side_q   <= side_d;
         duty_l_q <= duty_l_d;
         duty_r_q <= duty_r_d;
         busy_q   <= busy_d;
      end
   end

   assign duty_l = duty_l_q;
   assign duty_r = duty_r_q;
   assign busy   = busy_q;
   assign side   = side_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer: default and fast-tick instances.
module tb_tail_light_sequencer;

   typedef struct {
      int          cyc;
      int          dut;
      logic [23:0] dl;
      logic [23:0] dr;
      logic        busy;
      logic [1:0]  side;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0 = 1'b1, l0 = 1'b0, r0 = 1'b0, h0 = 1'b0;
   logic        rst1 = 1'b1, l1 = 1'b0, r1 = 1'b0, h1 = 1'b0;
   logic [23:0] dl0, dr0, dl1, dr1;
   logic        b0, b1;
   logic [1:0]  s0, s1;

   int   cyc_now = 0;
   int   checks  = 0;
   int   fails   = 0;
   exp_t q[$];

   tail_light_sequencer dut0 (
      .clk(clk), .reset(rst0), .left(l0), .right(r0), .hazard(h0),
      .duty_l(dl0), .duty_r(dr0), .busy(b0), .side(s0)
   );

   tail_light_sequencer #(.TICK_DIV(1), .HOLD_TICKS(1)) dut1 (
      .clk(clk), .reset(rst1), .left(l1), .right(r1), .hazard(h1),
      .duty_l(dl1), .duty_r(dr1), .busy(b1), .side(s1)
   );

   always @(posedge clk) cyc_now <= cyc_now + 1;

   // Expected lamp pattern k cycles after a sequence start
   function automatic logic [23:0] exp_pat(input int k, input int td, input int ht);
      logic [23:0] v;
      int s, lamp, lv;
      v = '0;
      s = k / td;
      if (s < 12) begin
         lamp = s / 4;
         case (s % 4)
            0:       lv = 3;
            1:       lv = 15;
            2:       lv = 63;
            default: lv = 255;
         endcase
         for (int i = 0; i < 3; i++) begin
            if (i < lamp)       v[i*8 +: 8] = 8'hFF;
            else if (i == lamp) v[i*8 +: 8] = 8'(lv);
         end
      end else if (s < 12 + ht) begin
         v = 24'hFFFFFF;
      end
      return v;
   endfunction

   task automatic push(input int d, input logic [23:0] dl, input logic [23:0] dr,
                       input logic b, input logic [1:0] sd, input string nm);
      exp_t e;
      e.cyc  = cyc_now + 1;
      e.dut  = d;
      e.dl   = dl;
      e.dr   = dr;
      e.busy = b;
      e.side = sd;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic push_seq(input int d, input int k, input int td, input int ht,
                           input logic [1:0] sd, input string nm);
      logic [23:0] p;
      if (k < (13 + ht) * td) begin
         p = exp_pat(k, td, ht);
         push(d, sd[1] ? p : 24'h0, sd[0] ? p : 24'h0, 1'b1, sd, nm);
      end else begin
         push(d, 24'h0, 24'h0, 1'b0, 2'b00, nm);
      end
   endtask

   task automatic drv0(input logic rst, input logic l, input logic r, input logic h);
      @(posedge clk);
      #1;
      rst0 = rst; l0 = l; r0 = r; h0 = h;
   endtask

   task automatic drv1(input logic rst, input logic l, input logic r, input logic h);
      @(posedge clk);
      #1;
      rst1 = rst; l1 = l; r1 = r; h1 = h;
   endtask

   task automatic run0(input logic l, input logic r, input logic h, input int k0,
                       input int k1, input logic [1:0] sd, input string nm);
      for (int k = k0; k <= k1; k++) begin
         drv0(1'b0, l, r, h);
         push_seq(0, k, 4, 2, sd, nm);
      end
   endtask

   // Monitor: compare every DUT output sample against the scoreboard entry for that cycle
   initial begin
      exp_t e;
      logic [52:0] act, want;
      forever begin
         @(posedge clk);
         #3;
         while (q.size() > 0 && q[0].cyc <= cyc_now) begin
            e = q.pop_front();
            if (e.dut == 0) act = {dl0, dr0, b0, s0};
            else            act = {dl1, dr1, b1, s1};
            want = {e.dl, e.dr, e.busy, e.side};
            checks++;
            if (e.cyc != cyc_now || act !== want) begin
               fails++;
               $display("FAIL %s dut%0d cyc %0d: got dl=%h dr=%h busy=%b side=%b, want dl=%h dr=%h busy=%b side=%b",
                        e.name, e.dut, cyc_now, act[52:29], act[28:5], act[2], act[1:0],
                        e.dl, e.dr, e.busy, e.side);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      // Reset state of both instances
      drv0(1'b1, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "reset0");
      push(1, 24'h0, 24'h0, 1'b0, 2'b00, "reset1");
      drv0(1'b1, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "reset0b");
      rst1 = 1'b0;

      // 1: single-cycle left pulse, full sequence then idle
      drv0(1'b0, 1'b1, 1'b0, 1'b0);
      push(0, 24'h000003, 24'h0, 1'b1, 2'b10, "s1_first");
      run0(1'b0, 1'b0, 1'b0, 1, 60, 2'b10, "s1_left");

      // 2: continuous right, one idle cycle between sequences
      run0(1'b0, 1'b1, 1'b0, 0, 60, 2'b01, "s2_right_a");
      run0(1'b0, 1'b1, 1'b0, 0, 3, 2'b01, "s2_right_b");
      drv0(1'b1, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "s2_cleanup");

      // 3: left+right together is ignored, then hazard drives both sides
      for (int i = 0; i < 20; i++) begin
         drv0(1'b0, 1'b1, 1'b1, 1'b0);
         push(0, 24'h0, 24'h0, 1'b0, 2'b00, "s3_both");
      end
      run0(1'b1, 1'b1, 1'b1, 0, 0, 2'b11, "s3_hazard");
      run0(1'b0, 1'b0, 1'b0, 1, 60, 2'b11, "s3_hazard");

      // 4: requests during a left sequence ignored; hazard starts next
      run0(1'b1, 1'b0, 1'b0, 0, 0, 2'b10, "s4_left");
      run0(1'b0, 1'b0, 1'b0, 1, 9, 2'b10, "s4_left");
      run0(1'b0, 1'b1, 1'b1, 10, 60, 2'b10, "s4_left_ignore");
      run0(1'b0, 1'b1, 1'b1, 0, 5, 2'b11, "s4_hazard_next");
      drv0(1'b1, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "s4_cleanup");

      // 5: reset mid-sequence aborts; reset beats a simultaneous request
      run0(1'b0, 1'b1, 1'b0, 0, 0, 2'b01, "s5_right");
      run0(1'b0, 1'b0, 1'b0, 1, 20, 2'b01, "s5_right");
      drv0(1'b0, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h000FFF, 1'b1, 2'b01, "s5_pre_reset");
      drv0(1'b1, 1'b0, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "s5_abort");
      drv0(1'b0, 1'b0, 1'b1, 1'b0);
      push(0, 24'h0, 24'h000003, 1'b1, 2'b01, "s5_restart");
      run0(1'b0, 1'b0, 1'b0, 1, 10, 2'b01, "s5_restart");
      drv0(1'b1, 1'b1, 1'b0, 1'b0);
      push(0, 24'h0, 24'h0, 1'b0, 2'b00, "s5_reset_wins");
      run0(1'b1, 1'b0, 1'b0, 0, 0, 2'b10, "s5_after_reset");
      run0(1'b0, 1'b0, 1'b0, 1, 60, 2'b10, "s5_after_reset");

      // 6: fast instance, one step per cycle, 14-cycle busy window
      drv1(1'b0, 1'b0, 1'b1, 1'b0);
      push(1, 24'h0, 24'h000003, 1'b1, 2'b01, "s6_first");
      drv1(1'b0, 1'b0, 1'b0, 1'b0);
      push(1, 24'h0, 24'h00000F, 1'b1, 2'b01, "s6_second");
      for (int k = 2; k <= 15; k++) begin
         drv1(1'b0, 1'b0, 1'b0, 1'b0);
         push_seq(1, k, 1, 1, 2'b01, "s6_fast");
      end

      repeat (3) @(posedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
